hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage RV32I pipeline (fetch, decode, execute, memory, writeback, plus the writeback pipe register).
//  - Tracks in-flight destinations in a scoreboard shift register.
//  - Generates forwarding selects, load-use stalls, branch/jump flushes and memory-wait freezes.
//  - Sits beside the core's stage pipes. It drives their enable/flush controls and the execute-stage operand muxes.
// PARAMETERS
//  REG_AW       5    register-index width (32 GPRs; x0 never a hazard)
//  TRACK_DEPTH  4    in-flight stages tracked after decode (EX, MEM, WB, WB-pipe)
//  SEL_W        3    forwarding-select width, >= clog2(TRACK_DEPTH+1)
//  MEM_TIMEOUT  255  cycles of unanswered data-memory request before mem_err
// PORTS
//  clk             in   1      core clock
//  rst             in   1      asynchronous, active-low reset
//  dec_valid       in   1      decode holds a real instruction
//  dec_rs1         in   REG_AW decode source 1
//  dec_rs2         in   REG_AW decode source 2
//  dec_use_rs1     in   1      instruction reads rs1
//  dec_use_rs2     in   1      instruction reads rs2
//  dec_rd          in   REG_AW decode destination
//  dec_rd_we       in   1      instruction writes rd
//  dec_is_load     in   1      instruction is a load
//  ex_redirect     in   1      execute: jump, or branch taken (next_sel | branch_result)
//  mem_request     in   1      memory stage issuing data-memory request
//  mem_valid       in   1      data memory response valid
//  stall_fetch     out  1      hold PC and fetch pipe
//  stall_decode    out  1      hold decode pipe input
//  flush_decode    out  1      squash fetch->decode register
//  flush_execute   out  1      insert bubble into decode->execute register
//  freeze          out  1      hold every pipe register (memory wait)
//  fwd_a_sel       out  SEL_W  operand A source: 0 = regfile, k = tracked stage k
//  fwd_b_sel       out  SEL_W  operand B source, same encoding
//  mem_err         out  1      sticky: memory timeout
// BEHAVIOUR
//  Reset (rst=0, async):
//  - scoreboard all invalid, FSM=RUN, wait counter=0.
//  - all outputs 0. Outputs are combinational from registered state plus current inputs.
//  Scoreboard entry[k], k=0..TRACK_DEPTH-1, holds {valid, rd, is_load}:
//  - valid means dec_rd_we & rd!=0.
//  - Normal advance: entry[0] <= decode info (bubble if dec_valid=0 or flush/stall); entry[k] <= entry[k-1].
//  - freeze=1: no entry shifts.
//  Hazard match: rsX used, rsX!=0, entry[k].valid, entry[k].rd==rsX. The lowest k wins (youngest producer).
//  FSM states RUN, LU_STALL, MEM_WAIT, FLUSH. Priority on simultaneous events: MEM_WAIT > FLUSH > LU_STALL.
//  - RUN -> MEM_WAIT when mem_request & !mem_valid. freeze=1 while in MEM_WAIT.
//  - MEM_WAIT -> RUN in the cycle mem_valid=1. freeze deasserts that same cycle; the counter clears.
//  - Counter reaching MEM_TIMEOUT sets mem_err, which stays set until reset. The FSM stays in MEM_WAIT.
//  - RUN -> FLUSH on ex_redirect. That cycle: flush_decode=1, flush_execute=1, entry[0] gets a bubble. FLUSH -> RUN after one cycle.
//  - A redirect arriving during LU_STALL wins: the stall is dropped and the flush is taken.
//  - RUN -> LU_STALL when a source matches entry[0] and entry[0].is_load.
//    Outputs: stall_fetch=1, stall_decode=1, flush_execute=1, entry[0] gets a bubble. Exactly 1 stall cycle, then RUN.
//  - fwd_*_sel is valid only in RUN with no stall. It is 0 while stalled or flushing.
//  Reset mid-stall or mid-wait returns to RUN immediately. Any partial wait count is discarded.
// CONFIGURATION
//  HAZARD_FWD_EN defined: forwarding active as above; only load-use (entry[0] load) stalls.
//  HAZARD_FWD_EN undefined:
//  - fwd_*_sel tied to 0.
//  - Any match in any entry stalls (stall_fetch, stall_decode, flush_execute) until no tracked entry matches. There is no 1-cycle limit.
//  - LU_STALL is held for the duration.
// STRUCTURE
//  Package hazard_pkg: state enum (RUN, LU_STALL, MEM_WAIT, FLUSH) and the scoreboard entry struct {valid, rd, is_load}.
//  Sub-module hazard_match: combinational comparator, one source against all entries. Outputs hit and lowest hit index. Instantiated twice (rs1, rs2).
// TESTING
//  1. Reset sanity: rst=0 mid-MEM_WAIT (counter=10) -> all outputs 0, state RUN next cycle after release.
//  2. Forwarding: add x5 then add x6,x5,x1 -> fwd_a_sel=1, no stall. With one instruction between -> fwd_a_sel=2.
//  3. Load-use: lw x7 then add x8,x7,x7 -> 1 cycle stall_fetch/stall_decode/flush_execute, then fwd_a_sel=fwd_b_sel=2.
//  4. x0 and unused sources: writer of x0, or rs2 with dec_use_rs2=0 -> no match, no stall.
//  5. Redirect: ex_redirect=1 during load-use stall -> flush_decode=flush_execute=1, stall dropped, entry[0] bubble.
//  6. Memory wait: mem_request=1, mem_valid low 3 cycles -> freeze=1 for exactly 3 cycles, scoreboard unchanged.
//     Held 255 cycles -> mem_err=1 sticky.
//  7. HAZARD_FWD_EN undefined: add x5 followed by use of x5 -> stall for 4 cycles (entry shifts out), fwd_*_sel=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the RV32I hazard/forwarding controller.
//   state_t     : controller FSM states (RUN, LU_STALL, MEM_WAIT, FLUSH)
//   sb_entry_t  : one scoreboard slot {valid, rd, is_load}
//   SB_RD_W     : register-index width held in a scoreboard slot. The
//                 controller's REG_AW parameter must not exceed it.
// -----------------------------------------------------------------------------
package hazard_pkg;

   localparam int SB_RD_W = 5;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      MEM_WAIT = 2'd2,
      FLUSH    = 2'd3
   } state_t;

   typedef struct packed {
      logic               valid;
      logic [SB_RD_W-1:0] rd;
      logic               is_load;
   } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational comparator: one decode source register against every
// scoreboard slot. The lowest matching slot (youngest producer) wins.
// Ports:
//   rs        in   REG_AW          source register index
//   use_rs    in   1               source is really read (already includes
//                                  the decode-valid qualifier)
//   entries   in   TRACK_DEPTH     scoreboard slots, [0] = youngest
//   hit       out  1               some slot produces rs
//   idx       out  SEL_W           0-based index of the youngest match
//   hit_load  out  1               the winning slot is a load
// -----------------------------------------------------------------------------
module hazard_match
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int TRACK_DEPTH = 4,
   parameter int SEL_W       = 3
) (
   input  logic [REG_AW-1:0]            rs,
   input  logic                         use_rs,
   input  sb_entry_t [TRACK_DEPTH-1:0]  entries,
   output logic                         hit,
   output logic [SEL_W-1:0]             idx,
   output logic                         hit_load
);

   // Scan oldest to youngest so that the youngest match overwrites.
   // x0 is hardwired zero and can never carry a hazard.
   always_comb begin
      hit      = 1'b0;
      idx      = '0;
      hit_load = 1'b0;
      if (use_rs && (rs != '0)) begin
         for (int k = TRACK_DEPTH - 1; k >= 0; k--) begin
            if (entries[k].valid && (entries[k].rd == SB_RD_W'(rs))) begin
               hit      = 1'b1;
               idx      = SEL_W'(k);
               hit_load = entries[k].is_load;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard / forwarding controller for a 5-stage RV32I pipeline. Tracks the
// destinations of in-flight instructions in a shift-register scoreboard and
// produces forwarding selects, load-use stalls, redirect flushes and the
// memory-wait freeze.
//
// Build option: HAZARD_FWD_EN
//   defined   : forwarding enabled, only a load in slot 0 stalls (one cycle).
//   undefined : forwarding selects tied to 0; any match in any slot stalls
//               until the producer has shifted out of the scoreboard.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   dec_valid                 decode holds a real instruction
//   dec_rs1/rs2, dec_use_rs*  decode sources and whether they are read
//   dec_rd, dec_rd_we         decode destination and write enable
//   dec_is_load               decode instruction is a load
//   ex_redirect               execute: jump or taken branch
//   mem_request, mem_valid    data-memory request / response
//   stall_fetch, stall_decode hold PC+fetch pipe / decode pipe input
//   flush_decode              squash fetch->decode register
//   flush_execute             bubble into decode->execute register
//   freeze                    hold every pipe register (memory wait)
//   fwd_a_sel, fwd_b_sel      0 = regfile, k = tracked stage k
//   mem_err                   sticky memory timeout
//   state                     current FSM state (observability)
//
// Priority when events coincide: memory wait > redirect > load-use stall.
// Outputs are combinational from registered state plus current inputs and
// are all held at 0 while rst is low.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int TRACK_DEPTH = 4,
   parameter int SEL_W       = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs1,
   input  logic [REG_AW-1:0] dec_rs2,
   input  logic              dec_use_rs1,
   input  logic              dec_use_rs2,
   input  logic [REG_AW-1:0] dec_rd,
   input  logic              dec_rd_we,
   input  logic              dec_is_load,
   input  logic              ex_redirect,
   input  logic              mem_request,
   input  logic              mem_valid,
   output logic              stall_fetch,
   output logic              stall_decode,
   output logic              flush_decode,
   output logic              flush_execute,
   output logic              freeze,
   output logic [SEL_W-1:0]  fwd_a_sel,
   output logic [SEL_W-1:0]  fwd_b_sel,
   output logic              mem_err,
   output state_t            state
);

   localparam int              CNT_W   = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   state_t                       state_q;
   sb_entry_t [TRACK_DEPTH-1:0]  sb_q;
   logic [CNT_W-1:0]             wait_cnt_q;
   logic                         mem_err_q;

   logic             hit_a, hit_b, load_a, load_b;
   logic [SEL_W-1:0] idx_a, idx_b;
   logic             frz_c, redirect_c, stall_c, push_c;
   logic [SEL_W-1:0] sel_a_c, sel_b_c;
   sb_entry_t        new_entry;

   hazard_match #(.REG_AW(REG_AW), .TRACK_DEPTH(TRACK_DEPTH), .SEL_W(SEL_W)) u_match_a (
      .rs       (dec_rs1),
      .use_rs   (dec_valid & dec_use_rs1),
      .entries  (sb_q),
      .hit      (hit_a),
      .idx      (idx_a),
      .hit_load (load_a)
   );

   hazard_match #(.REG_AW(REG_AW), .TRACK_DEPTH(TRACK_DEPTH), .SEL_W(SEL_W)) u_match_b (
      .rs       (dec_rs2),
      .use_rs   (dec_valid & dec_use_rs2),
      .entries  (sb_q),
      .hit      (hit_b),
      .idx      (idx_b),
      .hit_load (load_b)
   );

   // Entering the wait is decided by the live request so the freeze covers
   // the very first unanswered cycle; once waiting only the response counts.
   assign frz_c      = (state_q == MEM_WAIT) ? !mem_valid : (mem_request & !mem_valid);
   assign redirect_c = ex_redirect & !frz_c;

`ifdef HAZARD_FWD_EN
   // Only a load in slot 0 cannot be forwarded in time.
   assign stall_c = !frz_c & !ex_redirect &
                    ((hit_a & (idx_a == '0) & load_a) | (hit_b & (idx_b == '0) & load_b));
   assign sel_a_c = hit_a ? idx_a + 1'b1 : '0;
   assign sel_b_c = hit_b ? idx_b + 1'b1 : '0;
`else
   // Without forwarding every producer still in flight blocks the consumer.
   logic unused_match;
   assign unused_match = ^{idx_a, idx_b, load_a, load_b};
   assign stall_c = !frz_c & !ex_redirect & (hit_a | hit_b);
   assign sel_a_c = '0;
   assign sel_b_c = '0;
`endif

   // Squashed or stalled decode instructions enter the scoreboard as bubbles.
   assign push_c = dec_valid & dec_rd_we & (dec_rd != '0) & !redirect_c & !stall_c;

   always_comb begin
      new_entry = '0;
      if (push_c) begin
         new_entry.valid   = 1'b1;
         new_entry.rd      = SB_RD_W'(dec_rd);
         new_entry.is_load = dec_is_load;
      end
   end

   always_comb begin
      stall_fetch   = 1'b0;
      stall_decode  = 1'b0;
      flush_decode  = 1'b0;
      flush_execute = 1'b0;
      freeze        = 1'b0;
      fwd_a_sel     = '0;
      fwd_b_sel     = '0;
      if (rst) begin
         freeze        = frz_c;
         flush_decode  = redirect_c;
         flush_execute = redirect_c | stall_c;
         stall_fetch   = stall_c;
         stall_decode  = stall_c;
         if (!frz_c && !ex_redirect && !stall_c) begin
            fwd_a_sel = sel_a_c;
            fwd_b_sel = sel_b_c;
         end
      end
   end

   assign mem_err = mem_err_q;
   assign state   = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RUN;
         sb_q       <= '0;
         wait_cnt_q <= '0;
         mem_err_q  <= 1'b0;
      end else if (frz_c) begin
         // Scoreboard holds while frozen; the wait counter saturates.
         state_q <= MEM_WAIT;
         if (wait_cnt_q != CNT_MAX) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
         if (wait_cnt_q >= CNT_MAX - 1'b1) begin
            mem_err_q <= 1'b1;
         end
      end else begin
         wait_cnt_q <= '0;
         if (redirect_c) begin
            state_q <= FLUSH;
         end else if (stall_c) begin
            state_q <= LU_STALL;
         end else begin
            state_q <= RUN;
         end
         sb_q <= {sb_q[TRACK_DEPTH-2:0], new_entry};
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Bench for hazard_ctrl: directed pipeline scenarios followed by random
// traffic, every cycle compared against a list-of-in-flight-instructions
// reference model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
   import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       dec_valid, dec_use_rs1, dec_use_rs2, dec_rd_we, dec_is_load;
   logic [4:0] dec_rs1, dec_rs2, dec_rd;
   logic       ex_redirect, mem_request, mem_valid;
   logic       stall_fetch, stall_decode, flush_decode, flush_execute, freeze, mem_err;
   logic [2:0] fwd_a_sel, fwd_b_sel;
   state_t     state;

   hazard_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .dec_valid     (dec_valid),
      .dec_rs1       (dec_rs1),
      .dec_rs2       (dec_rs2),
      .dec_use_rs1   (dec_use_rs1),
      .dec_use_rs2   (dec_use_rs2),
      .dec_rd        (dec_rd),
      .dec_rd_we     (dec_rd_we),
      .dec_is_load   (dec_is_load),
      .ex_redirect   (ex_redirect),
      .mem_request   (mem_request),
      .mem_valid     (mem_valid),
      .stall_fetch   (stall_fetch),
      .stall_decode  (stall_decode),
      .flush_decode  (flush_decode),
      .flush_execute (flush_execute),
      .freeze        (freeze),
      .fwd_a_sel     (fwd_a_sel),
      .fwd_b_sel     (fwd_b_sel),
      .mem_err       (mem_err),
      .state         (state)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // In-flight producers, index 0 = instruction that left decode most recently.
   bit         m_v  [4];
   logic [4:0] m_rd [4];
   bit         m_ld [4];
   bit         m_wait;
   int         m_cnt;
   bit         m_err;

   bit last_stall, last_freeze;
   int last_fwd_a;

   function automatic int producer(input bit used, input logic [4:0] rs);
      if (!used || rs == 5'd0) return 0;
      for (int k = 0; k < 4; k++)
         if (m_v[k] && m_rd[k] == rs) return k + 1;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 4; k++) begin
         m_v[k] = 0; m_rd[k] = '0; m_ld[k] = 0;
      end
      m_wait = 0; m_cnt = 0; m_err = 0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      dec_valid = 0; dec_rs1 = '0; dec_rs2 = '0; dec_use_rs1 = 0; dec_use_rs2 = 0;
      dec_rd = '0; dec_rd_we = 0; dec_is_load = 0;
      ex_redirect = 0; mem_request = 0; mem_valid = 0;
   endtask

   task automatic instr(input logic [4:0] rd, input bit we, input bit ld,
                        input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2);
      dec_valid = 1; dec_rd = rd; dec_rd_we = we; dec_is_load = ld;
      dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
   endtask

   // One clock cycle: inputs already applied after the falling edge.
   task automatic cyc();
      int  pa, pb;
      bit  e_frz, e_redir, e_stall, push;
      int  e_fa, e_fb;
      #1;
      if (!rst) model_reset();
      pa = producer(dec_valid && dec_use_rs1, dec_rs1);
      pb = producer(dec_valid && dec_use_rs2, dec_rs2);
      e_frz   = m_wait ? !mem_valid : (mem_request && !mem_valid);
      e_redir = !e_frz && ex_redirect;
      if (FWD_EN) e_stall = !e_frz && !ex_redirect && m_ld[0] && (pa == 1 || pb == 1);
      else        e_stall = !e_frz && !ex_redirect && (pa != 0 || pb != 0);
      e_fa = 0; e_fb = 0;
      if (FWD_EN && !e_frz && !ex_redirect && !e_stall) begin
         e_fa = pa; e_fb = pb;
      end
      if (!rst) begin
         e_frz = 0; e_redir = 0; e_stall = 0; e_fa = 0; e_fb = 0;
      end
      check("stall_fetch",   32'(stall_fetch),   32'(e_stall));
      check("stall_decode",  32'(stall_decode),  32'(e_stall));
      check("flush_decode",  32'(flush_decode),  32'(e_redir));
      check("flush_execute", 32'(flush_execute), 32'(e_redir || e_stall));
      check("freeze",        32'(freeze),        32'(e_frz));
      check("fwd_a_sel",     32'(fwd_a_sel),     32'(e_fa));
      check("fwd_b_sel",     32'(fwd_b_sel),     32'(e_fb));
      check("mem_err",       32'(mem_err),       32'(m_err));
      last_stall  = stall_decode;
      last_freeze = freeze;
      last_fwd_a  = int'(fwd_a_sel);
      push = dec_valid && dec_rd_we && dec_rd != 5'd0 && !e_redir && !e_stall;
      @(posedge clk);
      if (rst) begin
         if (e_frz) begin
            m_wait = 1;
            m_cnt++;
            if (m_cnt >= 255) m_err = 1;
         end else begin
            m_wait = 0;
            m_cnt  = 0;
            for (int k = 3; k > 0; k--) begin
               m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
            end
            m_v[0] = push; m_rd[0] = push ? dec_rd : 5'd0; m_ld[0] = push && dec_is_load;
         end
      end
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      model_reset();
      idle();
      @(negedge clk);
      cyc();
      rst = 1;
      cyc();
      check("state_after_reset", 32'(state), 32'(RUN));

      // Reset in the middle of a memory wait discards the partial count.
      mem_request = 1; mem_valid = 0;
      for (int i = 0; i < 10; i++) cyc();
      rst = 0;
      cyc();
      rst = 1; mem_request = 0;
      cyc();
      check("state_run_after_mid_wait_reset", 32'(state), 32'(RUN));
      mem_request = 1;
      for (int i = 0; i < 250; i++) cyc();
      check("no_err_after_250", 32'(mem_err), 32'd0);
      mem_valid = 1; cyc();
      idle(); cyc();

      // Forwarding distance 1 and 2.
      instr(5, 1, 0, 1, 1, 2, 1); cyc();
      instr(6, 1, 0, 5, 1, 1, 1); cyc();
      idle(); for (int i = 0; i < 5; i++) cyc();
      instr(5, 1, 0, 1, 1, 2, 1); cyc();
      instr(9, 1, 0, 3, 1, 4, 1); cyc();
      instr(6, 1, 0, 5, 1, 1, 1); cyc();
      idle(); for (int i = 0; i < 5; i++) cyc();

      // Load-use: lw x7 ; add x8,x7,x7 held in decode while stalled.
      instr(7, 1, 1, 1, 1, 0, 0); cyc();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         instr(8, 1, 0, 7, 1, 7, 1); cyc();
         if (last_stall) n++;
         else break;
      end
      check("lu_stall_len", 32'(n), FWD_EN ? 32'd1 : 32'd4);
      check("lu_fwd_after", 32'(last_fwd_a), FWD_EN ? 32'd2 : 32'd0);
      idle(); for (int i = 0; i < 5; i++) cyc();

      // x0 writer and an unused rs2 never match.
      instr(0, 1, 1, 1, 1, 0, 0); cyc();
      instr(8, 1, 0, 0, 1, 0, 1); cyc();
      instr(3, 1, 1, 1, 1, 0, 0); cyc();
      instr(8, 1, 0, 1, 1, 3, 0); cyc();
      check("unused_rs2_no_stall", 32'(last_stall), 32'd0);
      idle(); for (int i = 0; i < 5; i++) cyc();

      // Redirect coinciding with a load-use hazard: flush wins.
      instr(7, 1, 1, 1, 1, 0, 0); cyc();
      instr(8, 1, 0, 7, 1, 7, 1); ex_redirect = 1; cyc();
      idle(); for (int i = 0; i < 5; i++) cyc();

      // Use of a plain ALU producer (stalls only without forwarding).
      instr(5, 1, 0, 1, 1, 2, 1); cyc();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         instr(6, 1, 0, 5, 1, 1, 1); cyc();
         if (last_stall) n++;
         else break;
      end
      check("alu_use_stall_len", 32'(n), FWD_EN ? 32'd0 : 32'd4);
      idle(); cyc();

      // Short memory wait: three unanswered cycles, producers held.
      instr(4, 1, 0, 1, 1, 2, 1); cyc();
      idle();
      mem_request = 1; mem_valid = 0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) mem_valid = 1;
         instr(9, 1, 0, 4, 1, 0, 0);
         cyc();
         if (last_freeze) n++;
      end
      check("freeze_len", 32'(n), 32'd3);
      idle(); for (int i = 0; i < 5; i++) cyc();

      // Long wait: mem_err after 255 cycles, sticky.
      mem_request = 1; mem_valid = 0;
      for (int i = 0; i < 254; i++) cyc();
      check("err_before_timeout", 32'(mem_err), 32'd0);
      cyc();
      check("err_at_timeout", 32'(mem_err), 32'd1);
      mem_valid = 1; cyc();
      idle(); for (int i = 0; i < 3; i++) cyc();
      check("err_sticky", 32'(mem_err), 32'd1);
      rst = 0; cyc();
      rst = 1; cyc();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         dec_valid   = ($urandom_range(0, 3) != 0);
         dec_rs1     = 5'($urandom_range(0, 7));
         dec_rs2     = 5'($urandom_range(0, 7));
         dec_use_rs1 = 1'($urandom_range(0, 1));
         dec_use_rs2 = 1'($urandom_range(0, 1));
         dec_rd      = 5'($urandom_range(0, 7));
         dec_rd_we   = ($urandom_range(0, 3) != 0);
         dec_is_load = ($urandom_range(0, 2) == 0);
         ex_redirect = ($urandom_range(0, 9) == 0);
         mem_request = ($urandom_range(0, 5) == 0);
         mem_valid   = 1'($urandom_range(0, 1));
         rst         = ($urandom_range(0, 299) != 0);
         cyc();
      end
      rst = 1;
      idle();
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
